trng_sampler: RTL and testbench

- Consumer of the divided 50 MHz clock produced by the clock-divider stage.
- Samples an asynchronous raw entropy bit and synchronises it.
- Applies von Neumann debiasing and packs the debiased bits into WORD_W-bit words.
- Publishes each word on a valid/ready interface to the downstream readout logic. An optional repetition-count health test can be compiled in.

---
 rtl/trng_sampler.sv | 155 +++++++++++++++
 tb/tb_trng_sampler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/trng_sampler.sv
// trng_sampler: synchronises a raw entropy bit, applies von Neumann debiasing,
// packs the debiased bits MSB-first into WORD_W-bit words and publishes them
// on a valid/ready interface with a sticky overflow flag.
// Optional repetition-count health test: define TRNG_HEALTH_EN.
module trng_sampler #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam int unsigned CntW = $clog2(WORD_W + 1);

    typedef enum logic [0:0] {StFirst, StSecond} pair_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_bit;

    pair_state_e            state_q, state_d;
    logic                   first_q, first_d;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   xfer;

    // Synchroniser chain; shifts every cycle regardless of en.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
        end
    end

    assign s_bit = sync_q[SYNC_STAGES-1];

    // Pair FSM, debiasing, packing and output handshake next-state logic.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        xfer    = valid_q & data_ready;

        if (xfer) begin
            valid_d = 1'b0;
        end

        if (!en) begin
            // Disabling abandons any partial pair and partial word.
            state_d = StFirst;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (state_q == StFirst) begin
            first_d = s_bit;
            state_d = StSecond;
        end else begin
            state_d = StFirst;
            if (s_bit != first_q) begin
                shreg_d = {shreg_q[WORD_W-2:0], first_q};
                if (cnt_q == CntW'(WORD_W - 1)) begin
                    cnt_d = '0;
                    if (!health_fail) begin
                        if (!valid_q || xfer) begin
                            data_d  = shreg_d;
                            valid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers for pair FSM, packer and output stage.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= StFirst;
            first_q <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overflow   = ovf_q;

`ifdef TRNG_HEALTH_EN
    localparam int unsigned RepW = $clog2(REP_LIMIT + 1);

    logic [RepW-1:0] rep_q, rep_d;
    logic            prev_q;
    logic            hf_q, hf_d;

    // Repetition counter: saturates at REP_LIMIT, restarts at 1 on any change.
    always_comb begin
        rep_d = rep_q;
        if (!en) begin
            rep_d = '0;
        end else if (rep_q == '0 || s_bit != prev_q) begin
            rep_d = RepW'(1);
        end else if (rep_q < RepW'(REP_LIMIT)) begin
            rep_d = rep_q + 1'b1;
        end
        hf_d = hf_q | (rep_d == RepW'(REP_LIMIT));
    end

    // Health-test registers; health_fail is sticky until reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            prev_q <= s_bit;
            hf_q   <= hf_d;
        end
    end

    assign health_fail = hf_q;
`else
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_sampler.sv
// Directed self-checking bench for trng_sampler (default parameters).
module tb_trng_sampler;

    logic       clk_in     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic       raw_bit    = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overflow;
    logic       health_fail;

    int checks   = 0;
    int failures = 0;

`ifdef TRNG_HEALTH_EN
    localparam logic HealthOn = 1'b1;
`else
    localparam logic HealthOn = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    trng_sampler dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        en      = 1'b0;
        raw_bit = 1'b0;
        repeat (n) tick();
    endtask

    // Drive n raw bits MSB-first; en rises once the first bit reaches s_bit
    // (or stays high throughout when keep is set). Two trailing cycles let the
    // last bit drain through the synchroniser and get consumed.
    task automatic send(input logic [63:0] bits, input int n, input bit keep);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) raw_bit = bits[n-1-i];
            else       raw_bit = 1'b0;
            en = keep || (i >= 2);
            tick();
        end
    endtask

    initial begin
        // 1: reset with raw_bit toggling, then synchroniser latency
        rst_n = 1'b0;
        repeat (2) begin
            raw_bit = ~raw_bit;
            tick();
        end
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_health", 32'(health_fail), 32'h0);
        rst_n   = 1'b1;
        raw_bit = 1'b1;
        tick();
        check("sync_lat_1", 32'(dut.s_bit), 32'h0);
        tick();
        check("sync_lat_2", 32'(dut.s_bit), 32'h1);
        idle(2);

        // 2: two words with immediate acceptance
        data_ready = 1'b1;
        send(64'h9999, 16, 1'b0);
        check("w_aa_valid", 32'(data_valid), 32'h1);
        check("w_aa_data", 32'(data_out), 32'hAA);
        idle(1);
        check("w_aa_one_cycle", 32'(data_valid), 32'h0);
        send(64'h55AA, 16, 1'b0);
        check("w_0f_valid", 32'(data_valid), 32'h1);
        check("w_0f_data", 32'(data_out), 32'h0F);
        idle(1);
        check("w_0f_one_cycle", 32'(data_valid), 32'h0);

        // 3: equal pairs only -> nothing emitted
        send(64'h3333_3333_3333_3333, 64, 1'b0);
        check("eq_valid", 32'(data_valid), 32'h0);
        check("eq_cnt", 32'(dut.cnt_q), 32'h0);
        idle(1);

        // 4: back-pressure and overflow
        data_ready = 1'b0;
        send(64'h9999, 16, 1'b0);
        check("bp_valid1", 32'(data_valid), 32'h1);
        check("bp_data1", 32'(data_out), 32'hAA);
        check("bp_ovf1", 32'(overflow), 32'h0);
        idle(1);
        send(64'h6666, 16, 1'b0);
        check("bp_valid2", 32'(data_valid), 32'h1);
        check("bp_data2_held", 32'(data_out), 32'hAA);
        check("bp_ovf2", 32'(overflow), 32'h1);
        data_ready = 1'b1;
        idle(1);
        check("bp_xfer_valid", 32'(data_valid), 32'h0);
        check("bp_ovf_sticky", 32'(overflow), 32'h1);
        check("bp_data_kept", 32'(data_out), 32'hAA);

        // 5a: 5 bits, reset for one cycle, then 11110000
        send(64'h2AA, 10, 1'b0);
        rst_n   = 1'b0;
        en      = 1'b1;
        raw_bit = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_clears_ovf", 32'(overflow), 32'h0);
        send(64'hAA55, 16, 1'b1);
        check("rst_mid_valid", 32'(data_valid), 32'h1);
        check("rst_mid_data", 32'(data_out), 32'hF0);
        idle(1);

        // 5b: 5 bits, en low for one cycle, then 11110000
        send(64'h2AA, 10, 1'b0);
        idle(1);
        send(64'hAA55, 16, 1'b1);
        check("en_low_valid", 32'(data_valid), 32'h1);
        check("en_low_data", 32'(data_out), 32'hF0);
        idle(2);

        // 6: constant source
        en      = 1'b1;
        raw_bit = 1'b1;
        repeat (40) tick();
        check("const_health", 32'(health_fail), 32'(HealthOn));
        check("const_valid", 32'(data_valid), 32'h0);
        send(64'h9999, 16, 1'b0);
        check("post_health_valid", 32'(data_valid), 32'(!HealthOn));
        check("post_health_ovf", 32'(overflow), 32'h0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
